uart_seq: RTL
=============

// Module: uart_seq
// PURPOSE
//  Register-port sequencer for the Paula-compatible uart (SERDAT/SERDATR/SERPER).
//  Lets a host byte-stream drive the uart instead of the CPU: programs SERPER,
//  writes SERDAT per tx byte, reads SERDATR when a byte arrives, and owns the
//  rbfmirror (INTREQ.RBF) handshake. Sits between the host bridge and uart core.
// PARAMETERS
//  PER_DEFAULT  16'h0010  SERPER value written after reset (bit15 forced 0: 8N1)
//  RD_LAT       1         cycles from SERDATR address to valid uart_dat_r (1..2)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  cfg_per        in   15  new baud period (SERPER[14:0])
//  cfg_wr         in   1   pulse: request SERPER reprogram with cfg_per
//  tx_valid       in   1   host tx byte valid
//  tx_data        in   8   host tx byte
//  tx_ready       out  1   tx byte accepted when tx_valid&tx_ready
//  rx_valid       out  1   received byte valid
//  rx_data        out  8   received byte (SERDATR[7:0])
//  rx_ready       in   1   host takes rx byte when rx_valid&rx_ready
//  rx_ovr         out  1   1-cycle pulse: SERDATR[15] (OVRUN) seen on a read
//  uart_rga       out  8   uart register address (word address, reg[8:1]); 0 = idle
//  uart_dat_w     out  16  uart write data
//  uart_dat_r     in   16  uart read data (SERDATR)
//  uart_txint     in   1   uart tx-buffer-empty pulse
//  uart_rxint     in   1   uart rx-buffer-full pulse
//  uart_rbfmirror out  1   RBF status fed back to uart
//  busy           out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0 (tx_ready 0, rx_valid 0, uart_rga 0, uart_dat_w 0,
//    uart_rbfmirror 0, busy 0); FSM=INIT; tbe flag=1; cfg pending=0.
//  - Access rule: each register access drives uart_rga/uart_dat_w for exactly
//    1 cycle, then uart_rga=0. SERPER=8'h19, SERDAT=8'h18, SERDATR=8'h0C.
//  - States: INIT -> WR_PER (SERPER=PER_DEFAULT) -> IDLE.
//    IDLE priority: (1) cfg pending -> WR_PER {1'b0,cfg_per}, clear pending;
//    (2) uart_rbfmirror & rx slot empty -> RD_REQ -> RD_WAIT (RD_LAT cycles)
//        -> capture -> IDLE; (3) tx byte held & tbe -> WR_DAT -> IDLE.
//  - cfg_wr latched into pending in any state; multiple pulses before service
//    collapse to one, last cfg_per wins (cfg_per sampled at cfg_wr).
//  - WR_DAT writes 16'h0100|data (one stop bit); clears tbe. tbe set on
//    uart_txint; txint in same cycle as WR_DAT -> tbe ends 0 (write wins).
//  - uart_rbfmirror set on uart_rxint; cleared in capture cycle. rxint in the
//    capture cycle -> rbfmirror stays 1 (set wins).
//  - Capture: rx_data=uart_dat_r[7:0], rx_valid=1; rx_ovr pulses if bit15=1.
//    rx_valid held until rx_ready; while slot full no SERDATR read is issued
//    (uart sets OVRUN on further bytes; reported on next read).
//  - Tx holding register (1 entry): tx_ready=1 when empty; accept -> full;
//    emptied by WR_DAT. Latency tx accept -> SERDAT write: 2 cycles min if idle.
//  - rx byte to rx_valid: rxint +1 rbfmirror, +1 RD_REQ, +RD_LAT, +1 valid.
//  - rst mid-access: uart_rga drops to 0 immediately (async), held bytes lost.
// CONFIGURATION
//  UART_SEQ_TXFIFO_EN defined: tx holding register replaced by 4-entry FIFO;
//   tx_ready=0 only when 4 bytes held; bytes go out in order, one SERDAT per
//   tbe. Undefined: single holding register as above. Other behaviour identical.
// TESTING
//  1 Release rst -> exactly one SERPER write 16'h0010 within 3 cycles, busy 0 after.
//  2 tx 8'hAA then 8'h55 -> SERDAT 16'h01AA; 16'h0155 only after uart_txint.
//  3 Loop uart txd->rxd, send 8'h3C -> rx_valid, rx_data 8'h3C, rbfmirror 1->0.
//  4 Hold rx_ready 0, send 2 bytes -> no 2nd SERDATR read; on release 2nd read
//    returns OVRUN=1 -> rx_ovr pulse.
//  5 cfg_wr 0x0020 then 0x0040 while tx busy -> one SERPER write 16'h0040.
//  6 Assert rst during RD_WAIT -> uart_rga 0, rx_valid 0, INIT re-runs SERPER.

Source files
------------

// File: rtl/uart_seq.sv
// uart_seq: host byte-stream sequencer for the Paula-style uart register port
// (SERPER / SERDAT / SERDATR) including the rbfmirror handshake.
// Build option: define UART_SEQ_TXFIFO_EN to replace the single tx holding
// register with a 4-entry in-order tx FIFO.
module uart_seq #(
    parameter logic [15:0] PER_DEFAULT = 16'h0010,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] cfg_per,
    input  logic        cfg_wr,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_ovr,
    output logic [7:0]  uart_rga,
    output logic [15:0] uart_dat_w,
    input  logic [15:0] uart_dat_r,
    input  logic        uart_txint,
    input  logic        uart_rxint,
    output logic        uart_rbfmirror,
    output logic        busy
);
    localparam logic [7:0]  RGA_SERPER  = 8'h19;
    localparam logic [7:0]  RGA_SERDAT  = 8'h18;
    localparam logic [7:0]  RGA_SERDATR = 8'h0C;
    localparam int unsigned CNT_W       = 2;

    typedef enum logic [2:0] {
        S_INIT, S_WR_PER, S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_DAT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cfg_pend;
    logic [14:0]       cfg_val;
    logic              tbe;
    logic              tx_have, tx_push, tx_pop, tx_ready_nxt;
    logic [7:0]        tx_head;
    logic [7:0]        rga_nxt;
    logic [15:0]       dat_w_nxt;
    logic              cfg_take, capture;
    logic              rd_unused;

    // SERDATR bits between OVRUN and the data byte carry nothing we use
    assign rd_unused = ^uart_dat_r[14:8];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    // Next state and register-access selection (access issued on state entry)
    always_comb begin
        state_nxt = state;
        rga_nxt   = 8'h00;
        dat_w_nxt = 16'h0000;
        cfg_take  = 1'b0;
        capture   = 1'b0;
        tx_pop    = 1'b0;
        case (state)
            S_INIT: begin
                state_nxt = S_WR_PER;
                rga_nxt   = RGA_SERPER;
                dat_w_nxt = {1'b0, PER_DEFAULT[14:0]};
            end
            S_WR_PER: state_nxt = S_IDLE;
            S_IDLE: begin
                if (cfg_pend) begin
                    state_nxt = S_WR_PER;
                    rga_nxt   = RGA_SERPER;
                    dat_w_nxt = {1'b0, cfg_val};
                    cfg_take  = 1'b1;
                end else if (uart_rbfmirror && !rx_valid) begin
                    state_nxt = S_RD_REQ;
                    rga_nxt   = RGA_SERDATR;
                end else if (tx_have && tbe) begin
                    state_nxt = S_WR_DAT;
                    rga_nxt   = RGA_SERDAT;
                    dat_w_nxt = 16'h0100 | {8'h00, tx_head};
                    tx_pop    = 1'b1;
                end
            end
            S_RD_REQ: state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
                    state_nxt = S_IDLE;
                    capture   = 1'b1;
                end
            end
            S_WR_DAT: state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Registered uart port and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_rga   <= 8'h00;
            uart_dat_w <= 16'h0000;
            busy       <= 1'b0;
        end else begin
            uart_rga   <= rga_nxt;
            uart_dat_w <= dat_w_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

    // Read-latency counter, restarted by every SERDATR request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     wait_cnt <= '0;
        else if (state == S_RD_REQ)  wait_cnt <= '0;
        else if (state == S_RD_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Pending SERPER reprogram; a new request in the service cycle wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pend <= 1'b0;
            cfg_val  <= 15'h0000;
        end else if (cfg_wr) begin
            cfg_pend <= 1'b1;
            cfg_val  <= cfg_per;
        end else if (cfg_take) begin
            cfg_pend <= 1'b0;
        end
    end

    // Tx buffer empty flag; a SERDAT write in the same cycle as txint wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             tbe <= 1'b1;
        else if (tx_pop)     tbe <= 1'b0;
        else if (uart_txint) tbe <= 1'b1;
    end

    // RBF mirror; a new rxint in the capture cycle keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             uart_rbfmirror <= 1'b0;
        else if (uart_rxint) uart_rbfmirror <= 1'b1;
        else if (capture)    uart_rbfmirror <= 1'b0;
    end

    // Rx slot and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_ovr   <= 1'b0;
        end else begin
            rx_ovr <= capture & uart_dat_r[15];
            if (capture) begin
                rx_valid <= 1'b1;
                rx_data  <= uart_dat_r[7:0];
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign tx_push = tx_valid & tx_ready;

`ifdef UART_SEQ_TXFIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fill, fill_nxt;

    assign tx_have      = (fill != 3'd0);
    assign tx_head      = fifo_mem[rd_ptr];
    assign fill_nxt     = fill + 3'(tx_push) - 3'(tx_pop);
    assign tx_ready_nxt = (fill_nxt != 3'd4);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            fill   <= 3'd0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 2'd1;
            if (tx_pop)  rd_ptr <= rd_ptr + 2'd1;
            fill <= fill_nxt;
        end
    end
`else
    logic       tx_full, tx_full_nxt;
    logic [7:0] tx_hold;

    assign tx_have      = tx_full;
    assign tx_head      = tx_hold;
    assign tx_full_nxt  = tx_push ? 1'b1 : (tx_pop ? 1'b0 : tx_full);
    assign tx_ready_nxt = !tx_full_nxt;

    // Single tx holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_full <= 1'b0;
            tx_hold <= 8'h00;
        end else begin
            tx_full <= tx_full_nxt;
            if (tx_push) tx_hold <= tx_data;
        end
    end
`endif

    // Registered tx_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_ready <= 1'b0;
        else     tx_ready <= tx_ready_nxt;
    end

endmodule
